// File: rtl/pulse_width_encoder.sv
// ----------------------------------------------------------------------------
// pulse_width_encoder
//
// Sits between the per-transducer intensity/phase stream and the duty table
// memory. For every accepted input it forms IDX = intensity * modulation,
// presents it on the duty table bus, captures the table's 8-bit pulse width
// TABLE_LATENCY cycles later and emits it together with the matching
// (delayed) phase and a running transducer index. One burst covers DEPTH
// transducers and is started by START.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   START, MOD_IN     burst start pulse, modulation latched on START
//   DIN_VALID         INTENSITY_IN / PHASE_IN valid this cycle
//   DUTY_TABLE_IDX    table index (16-bit product) to the duty table bus
//   DUTY_TABLE_VALUE  table result from the duty table bus
//   DOUT_VALID        PULSE_WIDTH_OUT / PHASE_OUT / DOUT_IDX valid
//   BUSY              burst in progress (RUN or DRAIN)
//   DONE              one-cycle pulse after the last output of a burst
// ----------------------------------------------------------------------------
module pulse_width_encoder #(
    parameter int DEPTH         = 249,
    parameter int TABLE_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [7:0]  MOD_IN,
    input  logic        DIN_VALID,
    input  logic [7:0]  INTENSITY_IN,
    input  logic [7:0]  PHASE_IN,
    output logic [15:0] DUTY_TABLE_IDX,
    input  logic [7:0]  DUTY_TABLE_VALUE,
    output logic        DOUT_VALID,
    output logic [7:0]  PULSE_WIDTH_OUT,
    output logic [7:0]  PHASE_OUT,
    output logic [7:0]  DOUT_IDX,
    output logic        BUSY,
    output logic        DONE
);

    // Stage 1 is the IDX register, the last stage is the output register;
    // the table value is captured into the output register directly.
    localparam int         STAGES = TABLE_LATENCY + 2;
    localparam logic [7:0] LAST   = 8'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic                    done_q, done_d;
    logic [7:0]              mod_q;
    logic [7:0]              in_cnt_q;
    logic [7:0]              out_cnt_q;
    logic [15:0]             idx_q;
    logic [STAGES:1]         vld_pipe;
    logic [STAGES-1:1][7:0]  ph_pipe_q;
    logic [7:0]              pw_q;
    logic [7:0]              ph_out_q;
    logic [7:0]              dout_idx_q;

    logic accept;
    logic start_ok;
    logic load_out;

    // Inputs only enter the pipeline while RUN; IDLE and DRAIN drop them.
    assign accept   = DIN_VALID && (state_q == RUN);
    assign start_ok = START && (state_q == IDLE);
    // The item one stage before the output register sees its table value now.
    assign load_out = vld_pipe[STAGES-1];

    // ------------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE:  if (START) state_d = RUN;
            RUN:   if (accept && (in_cnt_q == LAST)) state_d = DRAIN;
            // The last output is on the bus this cycle: DONE follows it.
            DRAIN: if (vld_pipe[STAGES] && (dout_idx_q == LAST)) begin
                       state_d = IDLE;
                       done_d  = 1'b1;
                   end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Burst bookkeeping: modulation latch and in/out counters
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mod_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (start_ok) begin
                mod_q     <= MOD_IN;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if (accept)   in_cnt_q  <= in_cnt_q + 8'd1;
                if (load_out) out_cnt_q <= out_cnt_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath pipeline
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx_q     <= '0;
            vld_pipe  <= '0;
            ph_pipe_q <= '0;
        end else begin
            // IDX holds between accepted inputs.
            if (accept) idx_q <= 16'(INTENSITY_IN) * 16'(mod_q);
            vld_pipe     <= {vld_pipe[STAGES-1:1], accept};
            ph_pipe_q[1] <= PHASE_IN;
            for (int k = 2; k < STAGES; k++) begin
                ph_pipe_q[k] <= ph_pipe_q[k-1];
            end
        end
    end

    // Output register: pulse width, phase and index update together and
    // hold while no item is emitted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pw_q       <= '0;
            ph_out_q   <= '0;
            dout_idx_q <= '0;
        end else if (load_out) begin
            pw_q       <= DUTY_TABLE_VALUE;
            ph_out_q   <= ph_pipe_q[STAGES-1];
            dout_idx_q <= out_cnt_q;
        end
    end

    assign DUTY_TABLE_IDX  = idx_q;
    assign DOUT_VALID      = vld_pipe[STAGES];
    assign PULSE_WIDTH_OUT = pw_q;
    assign PHASE_OUT       = ph_out_q;
    assign DOUT_IDX        = dout_idx_q;
    assign BUSY            = (state_q != IDLE);
    assign DONE            = done_q;

endmodule
